// File: rtl/ddr2_pkg.sv
// Controller-port widths and sequencer state encoding shared by the DDR2
// sequential reader and writer.
package ddr2_pkg;

    localparam int ADDR_W  = 31;
    localparam int WDATA_W = 256;
    localparam int RDATA_W = 128;
    localparam int MASK_W  = 32;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } seq_state_t;

endpackage

// File: rtl/sync_fifo_fwft.sv
// Single-clock first-word-fall-through FIFO: the head entry is visible on dout
// whenever empty is low. Pushes while full and pops while empty are ignored.
module sync_fifo_fwft #(
    parameter int WIDTH      = 128,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  ddr2_clk,
    input  logic                  RST,
    input  logic                  push,
    input  logic                  pop,
    input  logic [WIDTH-1:0]      din,
    output logic [WIDTH-1:0]      dout,
    output logic                  empty,
    output logic                  full,
    output logic [DEPTH_LOG2:0]   count
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_reg;
    logic [DEPTH_LOG2-1:0] rd_ptr_reg;
    logic [DEPTH_LOG2:0]   count_reg;
    logic                  do_push;
    logic                  do_pop;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == DEPTH_CNT);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign count   = count_reg;
    assign dout    = mem[rd_ptr_reg];

    // Storage carries no reset; occupancy alone decides what is meaningful.
    always_ff @(posedge ddr2_clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    always_ff @(posedge ddr2_clk or negedge RST) begin
        if (!RST) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/ddr2_seq_reader.sv
// Issues a run of DDR2 read requests over a wrapping address window and
// buffers the returned beats in a FWFT FIFO, gating requests on FIFO credit.
module ddr2_seq_reader
    import ddr2_pkg::*;
#(
    parameter logic [29:0] address_step    = 30'd4,
    parameter logic [29:0] address_bottom  = 30'h0000_0000,
    parameter logic [29:0] address_top     = 30'h0200_0000 - address_step,
    parameter int unsigned beats_per_req   = 2,
    parameter int unsigned fifo_depth_log2 = 4
) (
    input  logic                       ddr2_clk,
    input  logic                       RST,
    input  logic                       start,
    input  logic [29:0]                length,
    output logic                       busy,
    output logic                       done,
    output logic                       err,
    output logic                       req,
    input  logic                       ack,
    output logic [ADDR_W-1:0]          addr,
    output logic                       read,
    output logic                       fin,
    output logic [WDATA_W-1:0]         data_write,
    output logic [MASK_W-1:0]          mask,
    input  logic                       valid,
    input  logic [RDATA_W-1:0]         data_read,
    input  logic                       rd_en,
    output logic [RDATA_W-1:0]         dout,
    output logic                       empty,
    output logic [fifo_depth_log2:0]   count
);

    localparam int          CNT_W      = int'(fifo_depth_log2) + 1;
    localparam int          OUT_W      = int'(fifo_depth_log2) + 2;
    localparam int unsigned FIFO_DEPTH = 2 ** fifo_depth_log2;

    seq_state_t       state_reg, state_next;
    logic [29:0]      remaining_reg, remaining_next;
    logic [29:0]      addr_reg, addr_next;
    logic [OUT_W-1:0] outstanding_reg, outstanding_next;
    logic             req_reg, req_next;
    logic             done_reg, done_next;
    logic             err_reg, err_next;

    logic             fire;
    logic             beat_expected;
    logic             push;
    logic             pop;
    logic             fifo_full;
    logic             start_accept;
    logic             err_event;
    logic             credit_ok;
    logic [CNT_W-1:0] count_next;
    logic [31:0]      credit_used;

    assign fire          = req_reg & ack;
    assign beat_expected = valid & (outstanding_reg != '0);
    assign push          = beat_expected & ~fifo_full;
    assign pop           = rd_en & ~empty;
    assign start_accept  = start & (state_reg == IDLE);
    assign err_event     = (ack & ~req_reg)
                         | (valid & (outstanding_reg == '0))
                         | (beat_expected & fifo_full);

    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + 1'b1;
        end else if (pop && !push) begin
            count_next = count - 1'b1;
        end
    end

    always_comb begin
        outstanding_next = outstanding_reg;
        if (fire) begin
            outstanding_next = outstanding_next + OUT_W'(beats_per_req);
        end
        if (beat_expected) begin
            outstanding_next = outstanding_next - 1'b1;
        end
    end

    // Space left once this cycle's pushes, pops and acks have settled.
    assign credit_used = 32'(count_next) + 32'(outstanding_next) + beats_per_req;
    assign credit_ok   = (credit_used <= FIFO_DEPTH);

    always_comb begin
        state_next     = state_reg;
        remaining_next = remaining_reg;
        addr_next      = addr_reg;
        done_next      = 1'b0;
        req_next       = 1'b0;
        err_next       = (start_accept ? 1'b0 : err_reg) | err_event;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    if (length != '0) begin
                        remaining_next = length;
                        addr_next      = address_bottom;
                        state_next     = RUN;
                    end else begin
                        done_next = 1'b1;
                    end
                end
            end
            RUN: begin
                if (fire) begin
                    remaining_next = remaining_reg - 1'b1;
                    addr_next      = (addr_reg == address_top) ? address_bottom
                                                               : addr_reg + address_step;
                    if (remaining_next == '0) begin
                        state_next = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if ((outstanding_reg == '0) && !valid) begin
                    done_next  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        // A raised request is held until acked, then always drops for a cycle.
        if (req_reg && !ack) begin
            req_next = 1'b1;
        end else if (!req_reg && (state_reg == RUN) && (remaining_next != '0) && credit_ok) begin
            req_next = 1'b1;
        end
    end

    always_ff @(posedge ddr2_clk or negedge RST) begin
        if (!RST) begin
            state_reg       <= IDLE;
            remaining_reg   <= '0;
            addr_reg        <= address_bottom;
            outstanding_reg <= '0;
            req_reg         <= 1'b0;
            done_reg        <= 1'b0;
            err_reg         <= 1'b0;
        end else begin
            state_reg       <= state_next;
            remaining_reg   <= remaining_next;
            addr_reg        <= addr_next;
            outstanding_reg <= outstanding_next;
            req_reg         <= req_next;
            done_reg        <= done_next;
            err_reg         <= err_next;
        end
    end

    sync_fifo_fwft #(
        .WIDTH      (RDATA_W),
        .DEPTH_LOG2 (int'(fifo_depth_log2))
    ) u_fifo (
        .ddr2_clk (ddr2_clk),
        .RST      (RST),
        .push     (push),
        .pop      (pop),
        .din      (data_read),
        .dout     (dout),
        .empty    (empty),
        .full     (fifo_full),
        .count    (count)
    );

    assign busy       = (state_reg != IDLE);
    assign done       = done_reg;
    assign err        = err_reg;
    assign req        = req_reg;
    assign addr       = {1'b0, addr_reg};
    assign fin        = req_reg & (remaining_reg == 30'd1);
    assign read       = 1'b1;
    assign data_write = '0;
    assign mask       = '0;

endmodule

// File: tb/tb_ddr2_seq_reader.sv
// Randomised bench for ddr2_seq_reader: the bench plays the DDR2 controller and
// the FIFO consumer, and checks every cycle against a queue-based model.
module tb_ddr2_seq_reader;

    localparam logic [29:0] STEP  = 30'd4;
    localparam logic [29:0] BOT   = 30'h0;
    localparam logic [29:0] TOP   = 30'h8;
    localparam int          BEATS = 2;
    localparam int          DEPTH = 16;

    logic          ddr2_clk = 1'b0;
    logic          RST = 1'b0;
    logic          start = 1'b0;
    logic [29:0]   length = '0;
    logic          busy, done, err, req, read, fin, empty;
    logic          ack = 1'b0;
    logic          valid = 1'b0;
    logic          rd_en = 1'b0;
    logic [30:0]   addr;
    logic [255:0]  data_write;
    logic [31:0]   mask;
    logic [127:0]  data_read = '0;
    logic [127:0]  dout;
    logic [4:0]    count;

    ddr2_seq_reader #(
        .address_step    (STEP),
        .address_bottom  (BOT),
        .address_top     (TOP),
        .beats_per_req   (BEATS),
        .fifo_depth_log2 (4)
    ) dut (
        .ddr2_clk   (ddr2_clk),
        .RST        (RST),
        .start      (start),
        .length     (length),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .req        (req),
        .ack        (ack),
        .addr       (addr),
        .read       (read),
        .fin        (fin),
        .data_write (data_write),
        .mask       (mask),
        .valid      (valid),
        .data_read  (data_read),
        .rd_en      (rd_en),
        .dout       (dout),
        .empty      (empty),
        .count      (count)
    );

    always #5 ddr2_clk = ~ddr2_clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Model state
    logic [127:0] mq[$];
    logic [127:0] pend[$];
    int           pend_t[$];
    logic [29:0]  ack_addr[$];
    bit           ack_fin[$];
    bit           running = 0, zero_pending = 0, err_m = 0;
    int           run_len = 0, req_idx = 0, beats_run = 0;
    bit           req_c = 0, busy_c = 0, fin_c = 0, req_hold = 0, prev_fire = 0;
    logic [29:0]  addr_c = '0;

    // Stimulus knobs
    int  ack_pct = 100, valid_pct = 100, pop_pct = 50, lat_min = 1, lat_max = 3;
    int  valid_budget = 1 << 30;
    bit  start_req = 0, inject_ack = 0, inject_valid = 0;
    logic [29:0] start_len = '0;

    function automatic void chk(string name, logic [127:0] got, logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at cycle %0d", name, got, exp, cyc);
        end
    endfunction

    function automatic logic [29:0] addr_of(int k);
        int slots;
        slots = int'((TOP - BOT) / STEP) + 1;
        return BOT + 30'((k % slots) * int'(STEP));
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic check_outputs();
        chk("empty", empty, mq.size() == 0);
        chk("count", count, mq.size());
        if (mq.size() > 0) chk("dout", dout, mq[0]);
        chk("err", err, err_m);
        chk("addr", addr, {1'b0, addr_of(req_idx)});
        chk("fin", fin, req && (run_len - req_idx == 1));
        chk("read", read, 1'b1);
        chk("data_write", data_write[127:0] | data_write[255:128], 128'd0);
        chk("mask", mask, 32'd0);
        chk("req_only_in_run", req && !running, 1'b0);
        if (req) chk("credit", (int'(count) + pend.size() <= DEPTH - BEATS), 1'b1);
        if (req_hold) chk("req_hold", req, 1'b1);
        if (prev_fire) chk("req_drop_after_ack", req, 1'b0);
        if (zero_pending) begin
            chk("zero_len_done", done, 1'b1);
            chk("zero_len_busy", busy, 1'b0);
            zero_pending = 0;
        end else if (done) begin
            chk("done_complete", running && (req_idx == run_len) && (pend.size() == 0), 1'b1);
            chk("busy_at_done", busy, 1'b0);
            running = 0;
        end else begin
            chk("busy", busy, running);
        end
        req_c  = req;
        busy_c = busy;
        fin_c  = fin;
        addr_c = addr[29:0];
    endtask

    task automatic drive_inputs();
        start = 1'b0; ack = 1'b0; valid = 1'b0; rd_en = 1'b0;
        data_read = rand128();
        if (start_req) begin
            start = 1'b1; length = start_len; start_req = 0;
        end
        if (req_c && ($urandom % 100 < ack_pct)) ack = 1'b1;
        if (inject_ack) begin
            ack = 1'b1; inject_ack = 0;
        end
        if (pend.size() > 0 && pend_t[0] <= cyc && valid_budget > 0 && ($urandom % 100 < valid_pct)) begin
            valid = 1'b1; data_read = pend[0]; valid_budget--;
        end
        if (inject_valid) begin
            valid = 1'b1; inject_valid = 0;
        end
        rd_en = ($urandom % 100 < pop_pct);
    endtask

    task automatic update_model();
        bit do_pop;
        cyc++;
        do_pop = rd_en && (mq.size() > 0);
        if (start && !busy_c) begin
            err_m = 0;
            if (length != 0) begin
                running = 1; run_len = int'(length); req_idx = 0; beats_run = 0;
            end else begin
                zero_pending = 1;
            end
        end
        if (ack && !req_c) err_m = 1;
        req_hold  = req_c && !ack;
        prev_fire = req_c && ack;
        if (req_c && ack) begin
            ack_addr.push_back(addr_c);
            ack_fin.push_back(fin_c);
            for (int b = 0; b < BEATS; b++) begin
                pend.push_back(rand128());
                pend_t.push_back(cyc + $urandom_range(lat_max, lat_min));
            end
            req_idx++;
        end
        if (valid) begin
            if (pend.size() == 0) begin
                err_m = 1;
            end else begin
                void'(pend_t.pop_front());
                if (mq.size() < DEPTH) begin
                    mq.push_back(pend.pop_front());
                    beats_run++;
                end else begin
                    void'(pend.pop_front());
                    err_m = 1;
                end
            end
        end
        if (do_pop) void'(mq.pop_front());
    endtask

    task automatic cycle();
        @(negedge ddr2_clk);
        check_outputs();
        drive_inputs();
        @(posedge ddr2_clk);
        update_model();
    endtask

    task automatic start_run(input logic [29:0] len);
        start_len = len; start_req = 1;
        ack_addr.delete(); ack_fin.delete();
        cycle();
    endtask

    task automatic run_until_idle(input int max_cycles);
        int n = 0;
        while ((running || zero_pending) && n < max_cycles) begin
            cycle(); n++;
        end
        chk("run_timeout", running || zero_pending, 1'b0);
    endtask

    task automatic drain_fifo();
        int n = 0;
        pop_pct = 100;
        while (mq.size() > 0 && n < 100) begin
            cycle(); n++;
        end
        chk("drain_timeout", mq.size(), 0);
    endtask

    task automatic do_reset();
        @(negedge ddr2_clk);
        RST = 1'b0;
        start = 1'b0; ack = 1'b0; valid = 1'b0; rd_en = 1'b0;
        mq.delete(); pend.delete(); pend_t.delete();
        running = 0; zero_pending = 0; err_m = 0; req_idx = 0; run_len = 0;
        req_c = 0; busy_c = 0; req_hold = 0; prev_fire = 0; start_req = 0;
        #1;
        chk("rst_req", req, 1'b0);
        chk("rst_addr", addr, 31'h0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_empty", empty, 1'b1);
        chk("rst_count", count, 5'd0);
        repeat (2) @(posedge ddr2_clk);
        @(negedge ddr2_clk);
        RST = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();

        // Basic run
        ack_pct = 50; valid_pct = 100; pop_pct = 60; lat_min = 2; lat_max = 3;
        start_run(30'd3);
        run_until_idle(300);
        chk("basic_nacks", ack_addr.size(), 3);
        if (ack_addr.size() == 3) begin
            chk("basic_addr0", ack_addr[0], 30'h0);
            chk("basic_addr1", ack_addr[1], 30'h4);
            chk("basic_addr2", ack_addr[2], 30'h8);
            chk("basic_fin", {ack_fin[0], ack_fin[1], ack_fin[2]}, 3'b001);
        end
        chk("basic_beats", beats_run, 6);
        chk("basic_err", err, 1'b0);
        drain_fifo();

        // Wrap
        pop_pct = 70;
        start_run(30'd4);
        run_until_idle(300);
        chk("wrap_nacks", ack_addr.size(), 4);
        if (ack_addr.size() == 4) begin
            chk("wrap_addr2", ack_addr[2], 30'h8);
            chk("wrap_addr3", ack_addr[3], 30'h0);
        end
        drain_fifo();

        // Backpressure: no pops until credit is exhausted
        pop_pct = 0; ack_pct = 100; valid_pct = 100; lat_min = 1; lat_max = 2;
        start_run(30'd20);
        repeat (60) cycle();
        chk("bp_acks", req_idx, 8);
        chk("bp_count", count, 5'd16);
        chk("bp_req", req, 1'b0);
        chk("bp_occupancy", int'(count) + pend.size(), DEPTH);
        pop_pct = 70;
        run_until_idle(2000);
        chk("bp_beats", beats_run, 40);
        drain_fifo();

        // Zero-length start
        start_run(30'd0);
        run_until_idle(5);
        repeat (3) cycle();
        chk("zero_no_req", req, 1'b0);

        // Simultaneous push and pop at occupancy 5
        pop_pct = 0; valid_budget = 5; lat_min = 1; lat_max = 1; ack_pct = 100;
        start_run(30'd4);
        for (int n = 0; n < 100; n++) begin
            if (mq.size() == 5 && pend.size() > 0 && pend_t[0] <= cyc) break;
            cycle();
        end
        valid_budget = 1; valid_pct = 100; pop_pct = 100;
        cycle();
        pop_pct = 0;
        #1;
        chk("pushpop_count5", count, 5'd5);
        valid_budget = 1 << 30; pop_pct = 60; lat_max = 3;
        run_until_idle(500);
        drain_fifo();

        // Protocol errors while idle, then cleared by start
        inject_ack = 1;
        cycle();
        #1;
        chk("stray_ack_err", err, 1'b1);
        chk("stray_ack_addr", addr, {1'b0, addr_of(req_idx)});
        inject_valid = 1;
        cycle();
        #1;
        chk("stray_valid_err", err, 1'b1);
        chk("stray_valid_count", count, 5'd0);
        start_run(30'd2);
        #1;
        chk("start_clears_err", err, 1'b0);
        run_until_idle(300);
        drain_fifo();

        // Randomised runs
        for (int r = 0; r < 6; r++) begin
            ack_pct = $urandom_range(100, 20);
            valid_pct = $urandom_range(100, 30);
            pop_pct = $urandom_range(100, 10);
            lat_min = 1; lat_max = $urandom_range(6, 1);
            start_run(30'($urandom_range(25, 1)));
            run_until_idle(3000);
            drain_fifo();
        end

        // Reset during DRAIN with 4 beats buffered
        ack_pct = 100; pop_pct = 0; valid_budget = 0; lat_min = 1; lat_max = 1;
        start_run(30'd3);
        for (int n = 0; n < 100 && req_idx < 3; n++) cycle();
        valid_budget = 4;
        for (int n = 0; n < 100 && mq.size() < 4; n++) cycle();
        #1;
        chk("pre_rst_busy", busy, 1'b1);
        chk("pre_rst_count", count, 5'd4);
        do_reset();
        valid_budget = 1 << 30; pop_pct = 60; lat_max = 3;
        start_run(30'd2);
        run_until_idle(300);
        chk("post_rst_nacks", ack_addr.size(), 2);
        if (ack_addr.size() > 0) chk("post_rst_addr0", ack_addr[0], 30'h0);
        drain_fifo();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ddr2_seq_reader.md
Name: ddr2_seq_reader

Overview:
Read-direction companion to the DDR2 sequential writer. It issues `length` read requests to the DDR2 controller port at an address that walks from address_bottom in address_step increments and wraps at address_top. The returned 128-bit beats go into an internal first-word-fall-through FIFO that a downstream consumer drains in the same clock domain. Credit-based request gating ensures returned data can never overflow the FIFO.

Parameters:
- address_step, 30'd4, address increment per acked request
- address_bottom, 30'h0000_0000, first address of every run; wrap target
- address_top, 30'h0200_0000 - address_step, last address before wrap
- beats_per_req, 2, number of valid beats the controller returns per acked read
- fifo_depth_log2, 4, FIFO depth = 2**fifo_depth_log2 entries of 128 bits; must satisfy depth >= beats_per_req

Ports:
- ddr2_clk  in  1  sole clock
- RST  in  1  asynchronous reset, active-low
- start  in  1  one-cycle pulse; begins a run; ignored unless idle
- length  in  30  number of read requests in the run, sampled on start
- busy  out  1  high from the cycle after start until done
- done  out  1  one-cycle pulse when the run's last beat has entered the FIFO
- err  out  1  sticky protocol-error flag; cleared only by reset or start
- req  out  1  read request to controller
- ack  in  1  controller accepts the current request
- addr  out  31  request address
- read  out  1  constant 1
- fin  out  1  = req & (remaining == 1); marks the last request of the run
- data_write  out  256  constant 0
- mask  out  32  constant 0
- valid  in  1  a read-data beat is present on data_read
- data_read  in  128  read-data beat
- rd_en  in  1  consumer pop
- dout  out  128  FIFO head; valid while !empty
- empty  out  1  FIFO empty
- count  out  fifo_depth_log2+1  FIFO occupancy

Behaviour:
- Reset values: req=0, addr=address_bottom, busy=0, done=0, err=0, FIFO empty (count=0, empty=1), state IDLE, remaining=0, outstanding=0.
- Reset asserted mid-run aborts everything. FIFO contents and outstanding beats are discarded. Beats arriving after reset release are treated as unexpected (err).
- State machine IDLE -> RUN -> DRAIN -> IDLE.
- IDLE, start with length != 0: remaining <= length, addr <= address_bottom, err <= 0, go to RUN.
- IDLE, start with length == 0: pulse done on the next cycle and stay in IDLE.
- RUN: on ack & req: remaining -= 1; addr advances (address_top -> address_bottom, otherwise + address_step); outstanding += beats_per_req. When remaining reaches 0, go to DRAIN.
- DRAIN: when outstanding == 0 and no valid beat is present this cycle, pulse done and go to IDLE.
- outstanding counts beats acked but not yet returned. Each valid beat decrements it. Simultaneous ack and valid gives a net change of beats_per_req - 1.
- req is a register. Once high it stays high until sampled with ack. It drops for at least the cycle after ack.
- req is set when: state is RUN, remaining_next != 0, and 2**fifo_depth_log2 - count_next - outstanding_next >= beats_per_req.
- The credit condition is monotone while req is held, because pops only add space and beats only move credit from outstanding to count. A raised req never needs withdrawal.
- ack while req=0: ignored, err <= 1.
- valid while outstanding == 0: beat dropped, err <= 1.
- Because of the credit guarantee, a push to a full FIFO cannot occur. If it does, the beat is dropped and err <= 1.
- FIFO write latency: a beat with valid at cycle n is on dout with empty=0 at cycle n+1.
- rd_en while empty is ignored.
- Simultaneous push and pop on a non-empty FIFO leaves count unchanged.
- Address arithmetic is 30-bit modular. Bit 30 of addr is always 0.
- start while busy is ignored.

Decomposition:
- Shared package ddr2_pkg holds the controller-port widths (ADDR_W=31, WDATA_W=256, RDATA_W=128, MASK_W=32) and the state enum {IDLE, RUN, DRAIN}. The writer will also use these.
- One sub-module, sync_fifo_fwft: parameterised width/depth, single clock, async active-low reset, ports push/pop/din/dout/empty/full/count.

Test Plan:
- Basic run: length=3, controller acks each req after 2 cycles and returns 2 beats 3 cycles later -> addrs 0x0, 0x4, 0x8; fin high only with the third req; 6 beats on dout in order; done once; err=0.
- Backpressure: depth 16, length=20, consumer never pops -> req stops after 8 acks, with count+outstanding=16. Start popping -> req resumes. All 40 beats delivered in order; count never exceeds 16.
- Wrap: address_top=30'h8, length=4 -> addrs 0x0, 0x4, 0x8, 0x0.
- Boundaries: start with length=0 -> done the next cycle, req never raised. ack and valid in the same cycle -> outstanding net +1. Push and pop in the same cycle at count=5 -> count stays 5.
- Errors: valid injected while idle -> beat dropped, err=1, count unchanged. ack with req=0 -> err=1, addr unchanged. The next start clears err.
- Reset mid-run: assert RST while in DRAIN with 4 beats in the FIFO -> all outputs at reset values, empty=1, and a subsequent run starts at address_bottom.
